// File: rtl/signed_div_64by32_if.sv
// Request/result bundle for the signed 64/32 divider.
// Latency: n/a (wiring only).
// Backpressure: n/a; the master must watch busy/done itself.
interface signed_div_64by32_if;
    logic        start;
    logic [63:0] dividend;
    logic [31:0] divisor;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic        overflow;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, div_by_zero, overflow
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, div_by_zero, overflow
    );
endinterface

// File: rtl/signed_div_64by32.sv
// Signed 64/32 truncating restoring divider; error flags enabled by macro SDIV_ERR_FLAGS_EN.
// Latency: done 34 cycles after the accepting edge (1 cycle for divide-by-zero / early overflow).
// Backpressure: none; start is sampled only in IDLE, busy is high in every other state.
module signed_div_64by32 (
    input  logic               clk,
    input  logic               rst_n,
    signed_div_64by32_if.slave bus
);

`ifdef SDIV_ERR_FLAGS_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

    state_t      state_q, state_d;
    logic [63:0] dvd_q, dvd_d;          // captured raw dividend
    logic [31:0] dvs_q, dvs_d;          // captured raw divisor
    logic [31:0] mag_dvs_q, mag_dvs_d;  // |divisor|
    logic [31:0] rem_q, rem_d;          // partial remainder
    logic [31:0] lo_q, lo_d;            // dividend low bits shifting out, quotient bits shifting in
    logic [4:0]  cnt_q, cnt_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] rmd_q, rmd_d;
    logic        dbz_q, dbz_d;
    logic        ovf_q, ovf_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [63:0] abs_dvd;
    logic [31:0] abs_dvs;
    logic [32:0] trial;
    logic        trial_ge;
    logic        fix_ovf;

    assign abs_dvd  = dvd_q[63] ? (~dvd_q + 64'd1) : dvd_q;
    assign abs_dvs  = dvs_q[31] ? (~dvs_q + 32'd1) : dvs_q;
    // Shift the next dividend bit into the partial remainder; 33 bits so the compare never wraps.
    assign trial    = {rem_q, lo_q[31]};
    assign trial_ge = (trial >= {1'b0, mag_dvs_q});
    // -2^31 is representable, +2^31 is not.
    assign fix_ovf  = neg_quo_q ? (lo_q > 32'h8000_0000) : (lo_q > 32'h7FFF_FFFF);

    // Next-state and next-output computation for the whole divider.
    always_comb begin
        state_d   = state_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        mag_dvs_d = mag_dvs_q;
        rem_d     = rem_q;
        lo_d      = lo_q;
        cnt_d     = cnt_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        quo_d     = quo_q;
        rmd_d     = rmd_q;
        dbz_d     = dbz_q;
        ovf_d     = ovf_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    dvd_d   = bus.dividend;
                    dvs_d   = bus.divisor;
                    state_d = PREP;
                end
            end
            PREP: begin
                neg_quo_d = dvd_q[63] ^ dvs_q[31];
                neg_rem_d = dvd_q[63];
                mag_dvs_d = abs_dvs;
                rem_d     = abs_dvd[63:32];
                lo_d      = abs_dvd[31:0];
                cnt_d     = 5'd0;
                if (dvs_q == 32'd0) begin
                    quo_d   = 32'hFFFF_FFFF;
                    rmd_d   = dvd_q[31:0];
                    dbz_d   = ERR_EN;
                    ovf_d   = 1'b0;
                    state_d = DONE;
                end else if (abs_dvd[63:32] >= abs_dvs) begin
                    // Quotient magnitude needs more than 32 bits; no point iterating.
                    quo_d   = 32'h8000_0000;
                    rmd_d   = 32'd0;
                    dbz_d   = 1'b0;
                    ovf_d   = ERR_EN;
                    state_d = DONE;
                end else begin
                    state_d = CALC;
                end
            end
            CALC: begin
                // Partial remainder stays below |divisor|, so the low 32 bits of the difference are exact.
                if (trial_ge) begin
                    rem_d = trial[31:0] - mag_dvs_q;
                end else begin
                    rem_d = trial[31:0];
                end
                lo_d  = {lo_q[30:0], trial_ge};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                dbz_d = 1'b0;
                if (fix_ovf) begin
                    quo_d = 32'h8000_0000;
                    rmd_d = 32'd0;
                    ovf_d = ERR_EN;
                end else begin
                    quo_d = neg_quo_q ? (~lo_q + 32'd1) : lo_q;
                    rmd_d = neg_rem_q ? (~rem_q + 32'd1) : rem_q;
                    ovf_d = 1'b0;
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // All state, datapath and output registers; reset clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            dvd_q     <= 64'd0;
            dvs_q     <= 32'd0;
            mag_dvs_q <= 32'd0;
            rem_q     <= 32'd0;
            lo_q      <= 32'd0;
            cnt_q     <= 5'd0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            quo_q     <= 32'd0;
            rmd_q     <= 32'd0;
            dbz_q     <= 1'b0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            mag_dvs_q <= mag_dvs_d;
            rem_q     <= rem_d;
            lo_q      <= lo_d;
            cnt_q     <= cnt_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            quo_q     <= quo_d;
            rmd_q     <= rmd_d;
            dbz_q     <= dbz_d;
            ovf_q     <= ovf_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.quotient    = quo_q;
    assign bus.remainder   = rmd_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.overflow    = ovf_q;

endmodule
